counter_scheduler: RTL and testbench
====================================

Name: counter_scheduler

Overview:
- Time-shares one external 8-bit up counter (sync clear, enable, free-running output) between NREQ requesters.
- Each requester asks for a measured interval of `target` clock ticks.
- The scheduler arbitrates round-robin, clears and enables the counter, watches its value, and pulses `done` to the owner when the count reaches target.
- Sits between the requesting blocks and the shared counter instance. It is the only driver of the counter's clear/enable.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, counter/target width in bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until done or withdrawn.
- target  in  NREQ*WIDTH  per-requester target count; slice i = target[i*WIDTH +: WIDTH].
- cnt_value  in  WIDTH  current output of the shared counter.
- cnt_clear  out  1  synchronous clear to counter, active-high.
- cnt_enable  out  1  count enable to counter.
- grant  out  NREQ  one-hot owner of the counter; all-zero when idle.
- done  out  NREQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grant=0, done=0, cnt_clear=0, cnt_enable=0, busy=0; tgt_q=0; last-grant pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If req != 0, choose the first asserted req scanning from (last+1) mod NREQ upward with wrap.
  - Register that index into grant (one-hot) and last.
  - Latch its target slice into tgt_q.
  - Go to CLEAR.
  - No req: stay in IDLE.
- CLEAR (exactly 1 cycle): cnt_clear=1, cnt_enable=0. Next state is RUN, so the counter reads 0 in the first RUN cycle.
- RUN:
  - cnt_enable = (cnt_value != tgt_q), combinational from state and cnt_value.
  - If cnt_value == tgt_q, go to DONE.
  - If req[owner] drops, abort: go to IDLE, clear grant, no done pulse.
- DONE (1 cycle):
  - done[owner]=1; grant stays asserted this cycle; cnt_enable=0.
  - Next state IDLE with grant cleared.
- Target/latency:
  - target changes after the grant edge are ignored (tgt_q is latched).
  - target=0: CLEAR -> RUN (match immediately) -> DONE; cnt_enable never asserted.
  - From the edge that samples req in IDLE, done is high in cycle T+3 (T+2 edges after that edge, counting CLEAR, T RUN-count cycles and the matching RUN cycle). Counter holds T afterwards.
- No wrap-around: the counter is stopped at tgt_q ≤ 2^WIDTH-1, so it never rolls over under scheduler control.
- Gap between grants: minimum one IDLE cycle, since DONE always returns to IDLE. Back-to-back owners are each cleared independently.
- Simultaneous events:
  - A new req arriving while busy waits. Non-owner reqs never affect the current operation.
  - An owner that still holds req during DONE re-enters arbitration in IDLE behind the others (round-robin from last).
- Mid-operation reset: immediate return to reset values, including cnt_enable=0. Counter contents are left as-is.
- Invariants:
  - grant is 0 or one-hot.
  - done ⊆ grant.
  - cnt_clear and cnt_enable are never both high.
  - busy == (state != IDLE).

Test Plan:
- Reset, then req=4'b0001, target0=5 with a behavioural counter model -> grant=0001 next cycle; cnt_clear one cycle; cnt_enable high 5 cycles; done[0] pulses with cnt_value=5, 8 cycles after the req-sampling edge; then busy=0.
- req=4'b1111 all held, targets 2,3,4,1; each requester drops req on its done -> grants in order 0,1,2,3; each done arrives with cnt_value equal to its own target; grant always one-hot.
- target=0 on requester 2 -> CLEAR, RUN, DONE with cnt_enable never high; done[2] pulses 2 edges after grant.
- Owner with target 200 drops req after 10 counts -> scheduler returns to IDLE, no done, cnt_enable=0 and counter frozen at 10; waiting requester 1 is granted next.
- reset pulled low mid-RUN at count 7 -> all outputs 0 asynchronously (before the next clk edge); after release, req0 and req3 both pending -> req0 granted first.
- Owner holds req through done with requester 1 also requesting -> requester 1 granted next, not the same owner; target=255 completes with counter at 255 and no wrap.

Source files
------------

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-sharing of one external up counter.
// Each requester asks for an interval of `target` ticks. The owner gets a
// clear cycle, then counts until the counter matches the latched target, and
// then receives a one-cycle done pulse. The owner dropping req aborts silently.
module counter_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] target,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [IDXW-1:0]   last_reg;
  logic [WIDTH-1:0]  tgt_q;
  logic [IDXW-1:0]   pick;
  logic              pick_valid;
  logic [NREQ-1:0]   pick_onehot;
  logic [WIDTH-1:0]  tgt_slice [NREQ];
  logic              owner_req;
  logic              match;

  // Per-requester target slices and one-hot decode of the arbitration winner.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign tgt_slice[gi]   = target[gi*WIDTH +: WIDTH];
      assign pick_onehot[gi] = (pick == IDXW'(gi));
    end
  endgenerate

  // The owner is the granted requester; only its req matters while busy.
  assign owner_req = |(grant & req);
  assign match     = (cnt_value == tgt_q);

  // Round-robin pick: first asserted req scanning upward from last+1 with wrap.
  // Scanning the offsets from far to near lets the nearest one win.
  always_comb begin
    pick       = last_reg;
    pick_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_reg) + k) % NREQ]) begin
        pick       = IDXW'((int'(last_reg) + k) % NREQ);
        pick_valid = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; a target match takes precedence over an abort.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = pick_valid ? CLEAR : IDLE;
      CLEAR:   state_next = RUN;
      RUN: begin
        if (match) begin
          state_next = DONE;
        end else if (!owner_req) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: counter control, completion pulse and busy flag.
  always_comb begin
    cnt_clear  = (state_reg == CLEAR);
    cnt_enable = (state_reg == RUN) && !match;
    done       = (state_reg == DONE) ? grant : '0;
    busy       = (state_reg != IDLE);
  end

  // Grant, round-robin pointer and latched target; target is frozen at grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      last_reg <= IDXW'(NREQ - 1);
      tgt_q    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick_onehot;
            last_reg <= pick;
            tgt_q    <= tgt_slice[pick];
          end
        end
        RUN: begin
          if (!match && !owner_req) begin
            grant <= '0;
          end
        end
        DONE: begin
          grant <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Testbench for counter_scheduler: behavioural shared counter, a round-robin
// reference model in plain arithmetic, and per-transaction latency checks.
module tb_counter_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] target = '0;
  logic [W-1:0]   cnt_value = 8'd90;
  logic           cnt_clear;
  logic           cnt_enable;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tgt_tb [N];
  int model_last = N - 1;

  counter_scheduler #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .target(target),
    .cnt_value(cnt_value), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // External 8-bit counter: sync clear, enable, no reset of its own.
  always @(posedge clk) begin
    if (cnt_clear) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
  end

  // Invariants sampled every falling edge while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      n_tests++;
      if ((grant & (grant - 4'd1)) !== 4'd0) begin
        n_fail++; $display("FAIL grant_onehot: grant=%b required zero or one-hot", grant);
      end
      n_tests++;
      if ((done & ~grant) !== 4'd0) begin
        n_fail++; $display("FAIL done_in_grant: done=%b grant=%b", done, grant);
      end
      n_tests++;
      if ((cnt_clear & cnt_enable) !== 1'b0) begin
        n_fail++; $display("FAIL clear_enable_excl: both high");
      end
    end
  end

  function automatic logic [N*W-1:0] pack_targets();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(tgt_tb[i]);
    return v;
  endfunction

  // Round-robin reference: first set bit after `last`, with wrap.
  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({grant, done, cnt_clear, cnt_enable, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b done=%b clr=%b en=%b busy=%b required all 0",
               grant, done, cnt_clear, cnt_enable, busy);
    end
    reset = 1'b1;
    model_last = N - 1;
  endtask

  // From an IDLE falling edge with req pending, the grant must appear one edge later.
  task automatic wait_grant(input int exp_idx);
    int n;
    n = 0;
    while (grant === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != 1) begin
      n_fail++; $display("FAIL grant_latency: %0d edges required 1", n);
    end
    n_tests++;
    if (grant !== (4'b0001 << exp_idx)) begin
      n_fail++; $display("FAIL grant_owner: grant=%b required %b", grant, 4'b0001 << exp_idx);
    end
    $display("[TB] grant requester %0d (observed %b)", exp_idx, grant);
    model_last = exp_idx;
  endtask

  // Follow one granted operation to its done pulse and the following IDLE cycle.
  task automatic serve(input int idx, input bit hold);
    int t, n, en_cnt, clr_cnt;
    logic [N-1:0] exp_g;
    t = tgt_tb[idx];
    exp_g = 4'b0001 << idx;
    n_tests++;
    if (cnt_clear !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL clear_cycle: clr=%b busy=%b required 1 1", cnt_clear, busy);
    end
    // Changing the target after the grant must not affect this operation.
    tgt_tb[idx] = $urandom_range(0, 30);
    target = pack_targets();
    n = 0;
    en_cnt = int'(cnt_enable);
    clr_cnt = int'(cnt_clear);
    while (done === '0 && n < 300) begin
      @(negedge clk);
      n++;
      en_cnt += int'(cnt_enable);
      clr_cnt += int'(cnt_clear);
    end
    n_tests++;
    if (n != t + 2) begin
      n_fail++; $display("FAIL done_latency: req %0d T=%0d done after %0d edges required %0d", idx, t, n, t + 2);
    end
    n_tests++;
    if (done !== exp_g || grant !== exp_g) begin
      n_fail++; $display("FAIL done_owner: done=%b grant=%b required %b", done, grant, exp_g);
    end
    n_tests++;
    if (cnt_value !== W'(t)) begin
      n_fail++; $display("FAIL done_count: cnt=%0d required %0d", cnt_value, t);
    end
    n_tests++;
    if (en_cnt != t || clr_cnt != 1) begin
      n_fail++; $display("FAIL enable_cycles: en=%0d clr=%0d required %0d 1", en_cnt, clr_cnt, t);
    end
    $display("[TB] done requester %0d target %0d after %0d edges, cnt=%0d", idx, t, n, cnt_value);
    if (!hold) req[idx] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (grant !== '0 || done !== '0 || busy !== 1'b0 || cnt_value !== W'(t)) begin
      n_fail++;
      $display("FAIL post_done_idle: grant=%b done=%b busy=%b cnt=%0d required 0 0 0 %0d",
               grant, done, busy, cnt_value, t);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    tgt_tb = '{5, 0, 0, 0};
    target = pack_targets();
    req = 4'b0001;
    wait_grant(0);
    serve(0, 1'b0);
  endtask

  task automatic test_all_four();
    logic [N-1:0] pending;
    int e;
    apply_reset();
    tgt_tb = '{2, 3, 4, 1};
    target = pack_targets();
    pending = 4'b1111;
    req = pending;
    for (int k = 0; k < N; k++) begin
      e = rr_pick(pending, model_last);
      n_tests++;
      if (e != k) begin
        n_fail++; $display("FAIL rr_order_model: pick %0d required %0d", e, k);
      end
      wait_grant(e);
      serve(e, 1'b0);
      pending[e] = 1'b0;
    end
  endtask

  task automatic test_target_zero();
    apply_reset();
    tgt_tb = '{9, 9, 0, 9};
    target = pack_targets();
    req = 4'b0100;
    wait_grant(2);
    serve(2, 1'b0);
  endtask

  task automatic test_abort();
    apply_reset();
    tgt_tb = '{200, 3, 0, 0};
    target = pack_targets();
    req = 4'b0011;
    wait_grant(0);
    repeat (10) @(negedge clk);
    n_tests++;
    if (cnt_value !== 8'd9 || cnt_enable !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: cnt=%0d en=%b required 9 1", cnt_value, cnt_enable);
    end
    req[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (grant !== '0 || done !== '0 || cnt_enable !== 1'b0 || busy !== 1'b0 || cnt_value !== 8'd10) begin
      n_fail++;
      $display("FAIL abort_idle: grant=%b done=%b en=%b busy=%b cnt=%0d required 0 0 0 0 10",
               grant, done, cnt_enable, busy, cnt_value);
    end
    $display("[TB] abort requester 0 at cnt=%0d", cnt_value);
    wait_grant(1);
    n_tests++;
    if (cnt_value !== 8'd10) begin
      n_fail++; $display("FAIL abort_frozen: cnt=%0d required 10", cnt_value);
    end
    serve(1, 1'b0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    tgt_tb = '{50, 0, 0, 0};
    target = pack_targets();
    req = 4'b0001;
    wait_grant(0);
    repeat (8) @(negedge clk);
    n_tests++;
    if (cnt_value !== 8'd7) begin
      n_fail++; $display("FAIL async_pre: cnt=%0d required 7", cnt_value);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({grant, done, cnt_clear, cnt_enable, busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: grant=%b done=%b clr=%b en=%b busy=%b required all 0",
               grant, done, cnt_clear, cnt_enable, busy);
    end
    $display("[TB] async reset mid-run at cnt=%0d", cnt_value);
    @(negedge clk);
    n_tests++;
    if (cnt_value !== 8'd7) begin
      n_fail++; $display("FAIL async_counter_kept: cnt=%0d required 7", cnt_value);
    end
    model_last = N - 1;
    tgt_tb = '{3, 0, 0, 2};
    target = pack_targets();
    req = 4'b1001;
    reset = 1'b1;
    wait_grant(rr_pick(4'b1001, model_last));
    serve(0, 1'b0);
    wait_grant(3);
    serve(3, 1'b0);
  endtask

  task automatic test_hold_and_max();
    int first;
    apply_reset();
    tgt_tb = '{255, 4, 0, 0};
    target = pack_targets();
    req = 4'b0011;
    wait_grant(0);
    serve(0, 1'b1);
    first = rr_pick(req, model_last);
    wait_grant(first);
    serve(first, 1'b0);
    wait_grant(rr_pick(req, model_last));
    serve(0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    logic [N-1:0] served;
    int e;
    bit hold;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) tgt_tb[i] = $urandom_range(0, 40);
      target = pack_targets();
      pending = N'($urandom_range(1, 15));
      served = '0;
      req = pending;
      for (int it = 0; it < 2 * N && pending != '0; it++) begin
        e = rr_pick(pending, model_last);
        wait_grant(e);
        hold = !served[e] && ($urandom_range(0, 1) == 1);
        served[e] = 1'b1;
        serve(e, hold);
        if (!hold) pending[e] = 1'b0;
      end
      n_tests++;
      if (req !== '0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL random_drain: req=%b busy=%b required 0 0", req, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_target_zero();
    test_abort();
    test_async_reset();
    test_hold_and_max();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
